// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator: 640x480@60 defaults,
// derived totals and sync windows, coordinate width and sync polarity helpers.
package vga_timing_pkg;

    localparam int COORD_W   = 12;
    localparam int MAX_TOTAL = 1 << COORD_W;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    function automatic logic sync_level(input logic asserted, input bit pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter 0..TOTAL-1 with terminal count and
// sync-window / active-region decode of the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = VGA_H_TOTAL,
    parameter int ACTIVE     = VGA_H_ACTIVE,
    parameter int SYNC_START = VGA_H_SYNC_START,
    parameter int SYNC_END   = VGA_H_SYNC_END
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               inc,
    output logic [COORD_W-1:0] cnt,
    output logic               tc,
    output logic               in_sync,
    output logic               in_active
);

    localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);
    // One extra bit so a window ending exactly at 4096 still compares correctly.
    localparam logic [COORD_W:0] SYNC_LO = (COORD_W+1)'(SYNC_START);
    localparam logic [COORD_W:0] SYNC_HI = (COORD_W+1)'(SYNC_END);
    localparam logic [COORD_W:0] ACT_HI  = (COORD_W+1)'(ACTIVE);

    logic [COORD_W:0] cnt_ext;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + COORD_W'(1);
        end
    end

    assign cnt_ext   = {1'b0, cnt};
    assign tc        = (cnt == LAST);
    assign in_sync   = (cnt_ext >= SYNC_LO) && (cnt_ext < SYNC_HI);
    assign in_active = (cnt_ext < ACT_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel divider, x/y counters, syncs, active, pulses, frame count.
// Optional VGA_TIMING_PIPE_ALIGN_EN delays hsync/vsync/active by PIPE_DELAY clk.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit HS_POL     = POL_ACTIVE_LOW,
    parameter bit VS_POL     = POL_ACTIVE_LOW,
    parameter int PIX_DIV    = 1,
    parameter int PIPE_DELAY = 2
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    output logic               pix_ce,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic [15:0]        frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_err_total
        $error("vga_timing_gen: raster total exceeds coordinate range");
    end
    if (PIX_DIV < 1) begin : g_err_div
        $error("vga_timing_gen: PIX_DIV must be at least 1");
    end
    if (PIPE_DELAY < 0) begin : g_err_pipe
        $error("vga_timing_gen: PIPE_DELAY must not be negative");
    end

    logic [DIV_W-1:0]   div_cnt;
    logic [COORD_W-1:0] h_cnt, v_cnt;
    logic               h_tc, v_tc, h_sync, v_sync, h_act, v_act;
    logic               hsync_r, vsync_r, active_r;
    logic               frame_done;
    logic               at_origin;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    assign pix_ce = rstb & en & (div_cnt == DIV_LAST);

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
    ) u_h_axis (
        .clk       (clk),
        .rstb      (rstb),
        .inc       (pix_ce),
        .cnt       (h_cnt),
        .tc        (h_tc),
        .in_sync   (h_sync),
        .in_active (h_act)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_v_axis (
        .clk       (clk),
        .rstb      (rstb),
        .inc       (pix_ce & h_tc),
        .cnt       (v_cnt),
        .tc        (v_tc),
        .in_sync   (v_sync),
        .in_active (v_act)
    );

    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

    // frame_done marks that a full frame has been scanned since reset, so the
    // count only advances at the start of frames that follow a completed one.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            x           <= '0;
            y           <= '0;
            hsync_r     <= ~HS_POL;
            vsync_r     <= ~VS_POL;
            active_r    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            frame_done  <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_ce) begin
                x           <= h_cnt;
                y           <= v_cnt;
                hsync_r     <= sync_level(h_sync, HS_POL);
                vsync_r     <= sync_level(v_sync, VS_POL);
                active_r    <= h_act & v_act;
                line_start  <= (h_cnt == '0);
                frame_start <= at_origin;
                if (at_origin && frame_done) begin
                    frame_count <= frame_count + 16'd1;
                end
                if (h_tc && v_tc) begin
                    frame_done <= 1'b1;
                end
            end
        end
    end

`ifdef VGA_TIMING_PIPE_ALIGN_EN
    if (PIPE_DELAY < 1) begin : g_err_pipe_len
        $error("vga_timing_gen: PIPE_DELAY must be at least 1 when alignment is enabled");
    end

    logic [PIPE_DELAY-1:0] hs_pipe, vs_pipe, act_pipe;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            hs_pipe  <= {PIPE_DELAY{~HS_POL}};
            vs_pipe  <= {PIPE_DELAY{~VS_POL}};
            act_pipe <= '0;
        end else begin
            hs_pipe[0]  <= hsync_r;
            vs_pipe[0]  <= vsync_r;
            act_pipe[0] <= active_r;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
                act_pipe[i] <= act_pipe[i-1];
            end
        end
    end

    assign hsync  = hs_pipe[PIPE_DELAY-1];
    assign vsync  = vs_pipe[PIPE_DELAY-1];
    assign active = act_pipe[PIPE_DELAY-1];
`else
    assign hsync  = hsync_r;
    assign vsync  = vsync_r;
    assign active = active_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, PIX_DIV=4, and a
// tiny active-high raster for vsync windows and frame counting.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIPE_ALIGN_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Instance A: defaults, PIX_DIV=1
    logic        rstb_a = 1'b0, en_a = 1'b1;
    logic        pce_a, hs_a, vs_a, act_a, ls_a, fs_a;
    logic [11:0] x_a, y_a;
    logic [15:0] fc_a;

    vga_timing_gen #(.PIPE_DELAY(2)) u_dut_a (
        .clk(clk), .rstb(rstb_a), .en(en_a), .pix_ce(pce_a), .x(x_a), .y(y_a),
        .hsync(hs_a), .vsync(vs_a), .active(act_a), .line_start(ls_a),
        .frame_start(fs_a), .frame_count(fc_a)
    );

    // Instance B: defaults, PIX_DIV=4
    logic        rstb_b = 1'b0, en_b = 1'b1;
    logic        pce_b, hs_b, vs_b, act_b, ls_b, fs_b;
    logic [11:0] x_b, y_b;
    logic [15:0] fc_b;

    vga_timing_gen #(.PIX_DIV(4), .PIPE_DELAY(2)) u_dut_b (
        .clk(clk), .rstb(rstb_b), .en(en_b), .pix_ce(pce_b), .x(x_b), .y(y_b),
        .hsync(hs_b), .vsync(vs_b), .active(act_b), .line_start(ls_b),
        .frame_start(fs_b), .frame_count(fc_b)
    );

    // Instance C: 16x8 raster, hsync 10..12, vsync 5..6, active-high syncs
    logic        rstb_c = 1'b0, en_c = 1'b1;
    logic        pce_c, hs_c, vs_c, act_c, ls_c, fs_c;
    logic [11:0] x_c, y_c;
    logic [15:0] fc_c;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(1), .PIPE_DELAY(2)
    ) u_dut_c (
        .clk(clk), .rstb(rstb_c), .en(en_c), .pix_ce(pce_c), .x(x_c), .y(y_c),
        .hsync(hs_c), .vsync(vs_c), .active(act_c), .line_start(ls_c),
        .frame_start(fs_c), .frame_count(fc_c)
    );

    int errs, hs_low, first_hs, act_cnt, kl, pce_cnt, ls_j1, ls_j2, vs_cnt, fs_cnt;
    int exp_x, hx, hy;
    logic exp_hs, exp_vs, exp_act, exp_ls;

    initial begin
        // ---------------- Instance A: reset, first line, freeze, mid-line reset
        repeat (3) @(negedge clk);
        check("rst_x", int'(x_a), 0);
        check("rst_y", int'(y_a), 0);
        check("rst_active", int'(act_a), 0);
        check("rst_hsync", int'(hs_a), 1);
        check("rst_vsync", int'(vs_a), 1);
        check("rst_pix_ce", int'(pce_a), 0);
        check("rst_frame_start", int'(fs_a), 0);
        check("rst_frame_count", int'(fc_a), 0);

        rstb_a = 1'b1;
        #1 check("pix_ce_after_release", int'(pce_a), 1);

        errs = 0; hs_low = 0; first_hs = -1; act_cnt = 0;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("first_x", int'(x_a), 0);
                check("first_frame_start", int'(fs_a), 1);
                check("first_line_start", int'(ls_a), 1);
                check("first_active", int'(act_a), (LAG == 0) ? 1 : 0);
            end
            kl = k - LAG;
            exp_hs  = !(kl >= 656 && kl < 752);
            exp_act = (kl >= 0 && kl < 640);
            if (int'(x_a) != k || y_a != 12'd0) errs++;
            if (hs_a !== exp_hs || act_a !== exp_act || vs_a !== 1'b1) errs++;
            if (k > 0 && (ls_a || fs_a)) errs++;
            if (!hs_a) begin
                hs_low++;
                if (first_hs < 0) first_hs = k;
            end
            if (act_a) act_cnt++;
        end
        check("line0_scan_errors", errs, 0);
        check("line0_last_x", int'(x_a), 799);
        check("hsync_low_count", hs_low, 96);
        check("hsync_first_low", first_hs, 656 + LAG);
        check("active_count", act_cnt, 640);

        @(negedge clk);
        check("line1_x", int'(x_a), 0);
        check("line1_y", int'(y_a), 1);
        check("line1_line_start", int'(ls_a), 1);
        check("line1_frame_start", int'(fs_a), 0);
        check("line1_frame_count", int'(fc_a), 0);

        repeat (300) @(negedge clk);
        check("pre_freeze_x", int'(x_a), 300);
        en_a = 1'b0;
        errs = 0;
        repeat (50) begin
            @(negedge clk);
            if (x_a != 12'd300 || y_a != 12'd1 || pce_a || ls_a || fs_a) errs++;
        end
        check("freeze_errors", errs, 0);
        en_a = 1'b1;
        @(negedge clk);
        check("resume_x", int'(x_a), 301);
        check("resume_y", int'(y_a), 1);

        repeat (399) @(negedge clk);
        check("pre_reset_x", int'(x_a), 700);
        check("pre_reset_hsync", int'(hs_a), 0);
        rstb_a = 1'b0;
        @(negedge clk);
        check("mid_rst_x", int'(x_a), 0);
        check("mid_rst_y", int'(y_a), 0);
        check("mid_rst_active", int'(act_a), 0);
        check("mid_rst_hsync", int'(hs_a), 1);
        check("mid_rst_vsync", int'(vs_a), 1);
        check("mid_rst_pix_ce", int'(pce_a), 0);
        check("mid_rst_frame_count", int'(fc_a), 0);
        rstb_a = 1'b1;
        @(negedge clk);
        check("post_rst_frame_start", int'(fs_a), 1);
        check("post_rst_x", int'(x_a), 0);

        // ---------------- Instance B: PIX_DIV=4
        rstb_b = 1'b1;
        errs = 0; pce_cnt = 0; ls_j1 = -1; ls_j2 = -1;
        for (int j = 1; j <= 3210; j++) begin
            @(negedge clk);
            exp_x  = (j >= 4) ? (((j - 4) / 4) % 800) : 0;
            exp_ls = (j == 4 || j == 3204);
            if (pce_b !== ((j % 4) == 3)) errs++;
            if (int'(x_b) != exp_x) errs++;
            if (ls_b !== exp_ls) errs++;
            if (fs_b !== (j == 4)) errs++;
            if (pce_b) pce_cnt++;
            if (ls_b) begin
                if (ls_j1 < 0) ls_j1 = j;
                else if (ls_j2 < 0) ls_j2 = j;
            end
        end
        check("div4_scan_errors", errs, 0);
        check("div4_pix_ce_count", pce_cnt, 802);
        check("div4_line_period", ls_j2 - ls_j1, 3200);
        check("div4_y_line1", int'(y_b), 1);

        // ---------------- Instance C: small raster, frames and polarity
        rstb_c = 1'b1;
        errs = 0; vs_cnt = 0; fs_cnt = 0;
        for (int k = 0; k < 390; k++) begin
            @(negedge clk);
            kl = k - LAG;
            if (kl < 0) begin
                exp_hs = 1'b0; exp_vs = 1'b0; exp_act = 1'b0;
            end else begin
                hx = kl % 16;
                hy = (kl / 16) % 8;
                exp_hs  = (hx >= 10 && hx < 13);
                exp_vs  = (hy >= 5 && hy < 7);
                exp_act = (hx < 8 && hy < 4);
            end
            if (int'(x_c) != k % 16 || int'(y_c) != (k / 16) % 8) errs++;
            if (hs_c !== exp_hs || vs_c !== exp_vs || act_c !== exp_act) errs++;
            if (ls_c !== ((k % 16) == 0) || fs_c !== ((k % 128) == 0)) errs++;
            if (int'(fc_c) != k / 128) errs++;
            if (vs_c) vs_cnt++;
            if (fs_c) fs_cnt++;
            if (k == 128) check("small_fc_frame1", int'(fc_c), 1);
            if (k == 256) check("small_fc_frame2", int'(fc_c), 2);
        end
        check("small_scan_errors", errs, 0);
        check("small_vsync_count", vs_cnt, 96);
        check("small_frame_starts", fs_cnt, 4);
        check("small_fc_end", int'(fc_c), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
